// File: rtl/alu_writeback.sv
// Write-back consumer for the ALU execute stage: 2-entry result FIFO, register-file commit,
// condition-code register, branch-condition evaluation and a per-register pending mask.
// Optional: define WB_FLAG_BYPASS_EN so cond_true sees the flags of the commit in flight.
module alu_writeback #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int DEPTH  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid,
    output logic                 ex_ready,
    input  logic [2:0]           ex_op,
    input  logic [REG_AW-1:0]    ex_rd,
    input  logic [DATA_W-1:0]    ex_result,
    input  logic [3:0]           ex_flags,
    input  logic                 rf_ready,
    output logic                 rf_we,
    output logic [REG_AW-1:0]    rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic [3:0]           ccr,
    input  logic [2:0]           cond_sel,
    output logic                 cond_true,
    output logic [2**REG_AW-1:0] busy_mask
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_INVERT = 3'b001;

    logic [REG_AW-1:0] mem_rd    [DEPTH];
    logic [DATA_W-1:0] mem_data  [DEPTH];
    logic [3:0]        mem_flags [DEPTH];
    logic              mem_inv   [DEPTH];
    logic [DEPTH-1:0]  vld;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [3:0]    ccr_next;

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign ex_ready = !full;

    // NOP and reserved ops complete the handshake but are dropped here.
    assign push = ex_valid && ex_ready && (ex_op == OP_ADD || ex_op == OP_INVERT);
    assign pop  = rf_we;

    assign rf_we    = !empty && rf_ready;
    assign rf_waddr = mem_rd[rd_ptr];
    assign rf_wdata = mem_data[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr]    <= ex_rd;
            mem_data[wr_ptr]  <= ex_result;
            mem_flags[wr_ptr] <= ex_flags;
            mem_inv[wr_ptr]   <= (ex_op == OP_INVERT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            if (push) begin
                wr_ptr      <= wr_ptr + PTR_ONE;
                vld[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + PTR_ONE;
                vld[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // INVERT only owns the Z flag; C, N and V survive it.
    always_comb begin
        ccr_next = ccr;
        if (mem_inv[rd_ptr]) begin
            ccr_next[1] = mem_flags[rd_ptr][1];
        end else begin
            ccr_next = mem_flags[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ccr <= '0;
        end else if (pop) begin
            ccr <= ccr_next;
        end
    end

    function automatic logic eval_cond(input logic [3:0] f, input logic [2:0] sel);
        logic r;
        case (sel)
            3'b000:  r = 1'b1;
            3'b001:  r = f[1];
            3'b010:  r = f[0];
            3'b011:  r = f[2];
            3'b100:  r = f[3];
            3'b101:  r = !f[1];
            3'b110:  r = !f[0];
            default: r = !f[2];
        endcase
        return r;
    endfunction

`ifdef WB_FLAG_BYPASS_EN
    assign cond_true = eval_cond(rf_we ? ccr_next : ccr, cond_sel);
`else
    assign cond_true = eval_cond(ccr, cond_sel);
`endif

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i]) begin
                busy_mask[mem_rd[i]] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback; inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [2:0]  ex_op;
    logic [2:0]  ex_rd;
    logic [15:0] ex_result;
    logic [3:0]  ex_flags;
    logic        rf_ready;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [3:0]  ccr;
    logic [2:0]  cond_sel;
    logic        cond_true;
    logic [7:0]  busy_mask;

    int errors = 0;
    int checks = 0;

    alu_writeback dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_op     (ex_op),
        .ex_rd     (ex_rd),
        .ex_result (ex_result),
        .ex_flags  (ex_flags),
        .rf_ready  (rf_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .ccr       (ccr),
        .cond_sel  (cond_sel),
        .cond_true (cond_true),
        .busy_mask (busy_mask)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [2:0] rd,
                         input logic [15:0] res, input logic [3:0] fl);
        ex_valid  = 1'b1;
        ex_op     = op;
        ex_rd     = rd;
        ex_result = res;
        ex_flags  = fl;
    endtask

    // accept at one edge, commit at the next (rf_ready assumed high)
    task automatic run_op(input logic [2:0] op, input logic [2:0] rd,
                          input logic [15:0] res, input logic [3:0] fl);
        drive(op, rd, res, fl);
        tick();
        ex_valid = 1'b0;
        tick();
    endtask

    logic exp_bypass;

    initial begin
`ifdef WB_FLAG_BYPASS_EN
        exp_bypass = 1'b1;
`else
        exp_bypass = 1'b0;
`endif
        rst_n = 1'b0; ex_valid = 1'b0; ex_op = 3'b010; ex_rd = '0;
        ex_result = '0; ex_flags = '0; rf_ready = 1'b0; cond_sel = 3'b000;
        #12 rst_n = 1'b1;
        tick();
        check("rst_ready", ex_ready, 1);
        check("rst_we", rf_we, 0);
        check("rst_ccr", ccr, 0);
        check("rst_busy", busy_mask, 0);

        // reset mid-operation discards the queued entry
        drive(3'b000, 3'd2, 16'h1234, 4'h0);
        tick();
        ex_valid = 1'b0;
        rf_ready = 1'b1;
        #1;
        check("t1_busy_pre", busy_mask, 8'h04);
        check("t1_we_pre", rf_we, 1);
        rst_n = 1'b0;
        #1;
        check("t1_we", rf_we, 0);
        check("t1_ccr", ccr, 0);
        check("t1_busy", busy_mask, 0);
        check("t1_ready", ex_ready, 1);
        #1 rst_n = 1'b1;
        tick();
        check("t1_we_after", rf_we, 0);

        // basic ADD latency and CCR load
        drive(3'b000, 3'd3, 16'h0000, 4'b0011);
        tick();
        ex_valid = 1'b0;
        #1;
        check("t2_we", rf_we, 1);
        check("t2_waddr", rf_waddr, 3);
        check("t2_wdata", rf_wdata, 16'h0000);
        check("t2_busy", busy_mask, 8'h08);
        tick();
        cond_sel = 3'b001;
        #1;
        check("t2_ccr", ccr, 4'b0011);
        check("t2_condZ", cond_true, 1);
        check("t2_busy_clr", busy_mask, 0);
        check("t2_we_off", rf_we, 0);
        cond_sel = 3'b010; #1 check("t2_condC", cond_true, 1);
        cond_sel = 3'b011; #1 check("t2_condN", cond_true, 0);
        cond_sel = 3'b101; #1 check("t2_condnZ", cond_true, 0);
        cond_sel = 3'b111; #1 check("t2_condnN", cond_true, 1);

        // INVERT touches only Z
        run_op(3'b000, 3'd0, 16'h5555, 4'b1101);
        check("t3_ccr_add", ccr, 4'b1101);
        run_op(3'b001, 3'd1, 16'hAAAA, 4'b0000);
        check("t3_inv0", ccr, 4'b1101);
        run_op(3'b001, 3'd1, 16'h5555, 4'b0010);
        check("t3_inv1", ccr, 4'b1111);
        cond_sel = 3'b100; #1 check("t3_condV", cond_true, 1);
        cond_sel = 3'b110; #1 check("t3_condnC", cond_true, 0);

        // NOP and reserved ops are consumed silently
        drive(3'b010, 3'd5, 16'hFFFF, 4'b0000);
        #1 check("t5_ready", ex_ready, 1);
        tick();
        ex_op = 3'b111;
        tick();
        ex_valid = 1'b0;
        #1;
        check("t5_we", rf_we, 0);
        check("t5_busy", busy_mask, 0);
        check("t5_ccr", ccr, 4'b1111);

        // stall fills the FIFO; commits drain in order
        rf_ready = 1'b0;
        drive(3'b000, 3'd4, 16'h0AAA, 4'b0000);
        tick();
        check("t4_ready1", ex_ready, 1);
        drive(3'b000, 3'd5, 16'h0BBB, 4'b0100);
        tick();
        check("t4_full", ex_ready, 0);
        check("t4_busy2", busy_mask, 8'h30);
        drive(3'b000, 3'd6, 16'h0CCC, 4'b1000);
        tick();
        check("t4_stall_ready", ex_ready, 0);
        check("t4_stall_busy", busy_mask, 8'h30);
        check("t4_stall_we", rf_we, 0);
        rf_ready = 1'b1;
        #1;
        check("t4_we", rf_we, 1);
        check("t4_waddr0", rf_waddr, 4);
        check("t4_wdata0", rf_wdata, 16'h0AAA);
        check("t4_nopass", ex_ready, 0);
        tick();
        check("t4_ready_pop", ex_ready, 1);
        check("t4_waddr1", rf_waddr, 5);
        check("t4_wdata1", rf_wdata, 16'h0BBB);
        check("t4_busy_pop", busy_mask, 8'h20);
        check("t4_ccr0", ccr, 4'b0000);
        tick();
        ex_valid = 1'b0;
        #1;
        check("t4_waddr2", rf_waddr, 6);
        check("t4_wdata2", rf_wdata, 16'h0CCC);
        check("t4_busy3", busy_mask, 8'h40);
        check("t4_ccr1", ccr, 4'b0100);
        tick();
        check("t4_ccr2", ccr, 4'b1000);
        check("t4_busy_end", busy_mask, 0);
        check("t4_we_end", rf_we, 0);

        // flag bypass while the head commits
        rf_ready = 1'b0;
        cond_sel = 3'b001;
        drive(3'b000, 3'd7, 16'h0001, 4'b0010);
        tick();
        ex_valid = 1'b0;
        #1;
        check("t6_pre", cond_true, 0);
        rf_ready = 1'b1;
        #1;
        check("t6_we", rf_we, 1);
        check("t6_bypass", cond_true, exp_bypass);
        tick();
        check("t6_post", cond_true, 1);
        check("t6_ccr", ccr, 4'b0010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
